// File: rtl/psram_bus_bridge.sv
// rtl/psram_bus_bridge.sv - CPU byte-bus to PSRAM controller bridge with a one-word read buffer
module psram_bus_bridge #(
  parameter int                ADDR_W       = 19,
  parameter logic [ADDR_W-1:0] WIN_BASE     = 19'h10000,
  parameter logic [ADDR_W-1:0] WIN_MASK     = 19'h70000,
  parameter logic [21:0]       PSRAM_OFFSET = 22'h000000,
  parameter int                TIMEOUT      = 255,
  parameter bit                CACHE_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte_write,
  output logic [21:0]       mem_addr,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  input  logic              mem_busy
);

  localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK} state_t;

  state_t           state, state_d;
  logic             req_q;
  logic             we_q;
  logic [7:0]       wdata_q;
  logic             buf_valid;
  logic [20:0]      buf_tag;
  logic [15:0]      buf_data;
  logic [CNT_W-1:0] cnt;

  logic             in_win;
  logic [21:0]      baddr_in;
  logic             accept, hit, issue, done, expired;

  assign in_win   = (cpu_addr & WIN_MASK) == WIN_BASE;
  assign baddr_in = PSRAM_OFFSET + 22'(cpu_addr & ~WIN_MASK);

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    hit     = 1'b0;
    issue   = 1'b0;
    done    = 1'b0;
    expired = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && !req_q && in_win) begin
          accept  = 1'b1;
          hit     = !cpu_we && buf_valid && (buf_tag == baddr_in[21:1]);
          state_d = hit ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          issue   = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (cnt == CNT_MAX) begin
          expired = 1'b1;
          state_d = ACK;
        end else if (mem_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A completion seen on the last counted cycle still wins over the timeout
        if (!mem_busy) begin
          done    = 1'b1;
          state_d = ACK;
        end else if (cnt == CNT_MAX) begin
          expired = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // mem_addr doubles as the latched byte address for the whole access
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      wdata_q        <= 8'h00;
      buf_valid      <= 1'b0;
      buf_tag        <= '0;
      buf_data       <= 16'h0000;
      cnt            <= '0;
      cpu_rdata      <= 8'h00;
      cpu_ack        <= 1'b0;
      cpu_err        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= 22'h000000;
      mem_din        <= 16'h0000;
    end else begin
      req_q          <= cpu_req;
      cpu_ack        <= 1'b0;
      cpu_err        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;

      if (state == WAIT_BUSY || state == WAIT_DONE) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end

      if (accept) begin
        we_q     <= cpu_we;
        wdata_q  <= cpu_wdata;
        mem_addr <= baddr_in;
        if (cpu_we) begin
          mem_din <= {cpu_wdata, cpu_wdata};
        end
      end

      if (hit) begin
        cpu_ack   <= 1'b1;
        cpu_rdata <= baddr_in[0] ? buf_data[15:8] : buf_data[7:0];
      end

      if (issue) begin
        mem_read       <= !we_q;
        mem_write      <= we_q;
        mem_byte_write <= we_q;
      end

      if (done) begin
        cpu_ack <= 1'b1;
        if (!we_q) begin
          buf_data  <= mem_dout;
          buf_tag   <= mem_addr[21:1];
          buf_valid <= CACHE_EN;
          cpu_rdata <= mem_addr[0] ? mem_dout[15:8] : mem_dout[7:0];
        end else if (buf_valid && buf_tag == mem_addr[21:1]) begin
          if (mem_addr[0]) begin
            buf_data[15:8] <= wdata_q;
          end else begin
            buf_data[7:0] <= wdata_q;
          end
        end
      end

      if (expired) begin
        cpu_ack   <= 1'b1;
        cpu_err   <= 1'b1;
        cpu_rdata <= 8'hFF;
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psram_bus_bridge.sv
// tb/tb_psram_bus_bridge.sv - scoreboard bench for psram_bus_bridge with a behavioural PSRAM controller
module tb_psram_bus_bridge;

  logic        clk;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte_write;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic        mem_busy;

  psram_bus_bridge #(.TIMEOUT(8)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack),
    .cpu_err        (cpu_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_write (mem_byte_write),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_busy       (mem_busy)
  );

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [15:0] din;
  } cmd_t;

  typedef struct {
    logic [7:0]  rdata;
    logic        chk_rdata;
    logic        err;
    logic        chk_addr;
    logic [21:0] addr;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cmd_seen = 0;
  int ack_seen = 0;
  int last_cmd_cyc = 0;
  int last_ack_cyc = 0;

  int          busy_cycles = 3;
  logic [15:0] dout_val    = 16'h0000;
  logic        mem_respond = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: busy rises the cycle after a command and drops with the read data
  initial begin
    mem_busy = 1'b0;
    mem_dout = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if ((mem_read || mem_write) && mem_respond) begin
        mem_busy = 1'b1;
        mem_dout = 16'h0000;
        repeat (busy_cycles) @(posedge clk);
        #1;
        mem_busy = 1'b0;
        mem_dout = dout_val;
      end
    end
  end

  always @(negedge clk) begin : monitor
    cmd_t c;
    rsp_t r;
    if (resetn) begin
      if (mem_read || mem_write) begin
        cmd_seen++;
        last_cmd_cyc = cyc;
        if (cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: rd=%0b wr=%0b addr=%0h expected none", mem_read, mem_write, mem_addr);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_write", 32'(mem_write), 32'(c.we));
          check("cmd_read", 32'(mem_read), 32'(!c.we));
          check("cmd_byte_write", 32'(mem_byte_write), 32'(c.we));
          check("cmd_addr", 32'(mem_addr), 32'(c.addr));
          if (c.we) check("cmd_din", 32'(mem_din), 32'(c.din));
        end
      end
      if (cpu_ack) begin
        ack_seen++;
        last_ack_cyc = cyc;
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: rdata=%0h err=%0b expected none", cpu_rdata, cpu_err);
        end else begin
          r = rsp_q.pop_front();
          check("ack_err", 32'(cpu_err), 32'(r.err));
          if (r.chk_rdata) check("ack_rdata", 32'(cpu_rdata), 32'(r.rdata));
          if (r.chk_addr) check("ack_mem_addr", 32'(mem_addr), 32'(r.addr));
        end
      end else if (cpu_err) begin
        total++;
        bad++;
        $display("FAIL err_without_ack: err=%0b expected 0", cpu_err);
      end
    end
  end

  // Called at posedge+1; inputs are scrambled after release to prove they were latched
  task automatic pulse_req(input logic we, input logic [18:0] addr, input logic [7:0] wd, input int hold);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    repeat (hold) @(posedge clk);
    #1;
    cpu_req   = 1'b0;
    cpu_we    = ~we;
    cpu_addr  = 19'h10033;
    cpu_wdata = 8'hEE;
  endtask

  task automatic wait_ack(input string name, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (cpu_ack) break;
    end
    if (!cpu_ack) begin
      total++;
      bad++;
      $display("FAIL %s_no_ack: got none within %0d cycles expected ack", name, lat);
    end
  endtask

  task automatic access(input logic we, input logic [18:0] addr, input logic [7:0] wd,
                        input logic expect_cmd, input logic [7:0] exp_rd, input logic exp_err,
                        input int exp_lat, input string name);
    int          lat;
    int          c0;
    cmd_t        c;
    rsp_t        r;
    logic [21:0] ba;
    ba = 22'(addr & 19'h0FFFF);
    if (expect_cmd) begin
      c.we   = we;
      c.addr = ba;
      c.din  = {wd, wd};
      cmd_q.push_back(c);
    end
    r.rdata     = exp_rd;
    r.chk_rdata = !we;
    r.err       = exp_err;
    r.chk_addr  = expect_cmd;
    r.addr      = ba;
    rsp_q.push_back(r);
    c0 = cmd_seen;
    pulse_req(we, addr, wd, 1);
    wait_ack(name, lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_ncmd"}, 32'(cmd_seen - c0), 32'(expect_cmd));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rdata"}, 32'(cpu_rdata), 32'h0);
    check({name, "_ack"}, 32'(cpu_ack), 32'h0);
    check({name, "_err"}, 32'(cpu_err), 32'h0);
    check({name, "_mem_read"}, 32'(mem_read), 32'h0);
    check({name, "_mem_write"}, 32'(mem_write), 32'h0);
    check({name, "_mem_bw"}, 32'(mem_byte_write), 32'h0);
    check({name, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({name, "_mem_din"}, 32'(mem_din), 32'h0);
  endtask

  initial begin
    int   ack0;
    int   cmd0;
    int   n;
    cmd_t c;
    rsp_t r;

    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 19'h0;
    cpu_wdata = 8'h0;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Read miss, then hits on both lanes of the captured word
    busy_cycles = 3;
    dout_val    = 16'hBEEF;
    access(1'b0, 19'h10005, 8'h00, 1'b1, 8'hBE, 1'b0, 6, "rd_miss");
    access(1'b0, 19'h10004, 8'h00, 1'b0, 8'hEF, 1'b0, 1, "rd_hit");

    // Write-through on a tag match; write miss does not allocate
    access(1'b1, 19'h10004, 8'h12, 1'b1, 8'h00, 1'b0, 6, "wr_hit");
    access(1'b0, 19'h10004, 8'h00, 1'b0, 8'h12, 1'b0, 1, "rd_after_wr");
    access(1'b0, 19'h10005, 8'h00, 1'b0, 8'hBE, 1'b0, 1, "rd_other_lane");
    access(1'b1, 19'h10010, 8'h34, 1'b1, 8'h00, 1'b0, 6, "wr_miss");
    dout_val = 16'h5678;
    access(1'b0, 19'h10010, 8'h00, 1'b1, 8'h78, 1'b0, 6, "rd_no_alloc");

    // Out-of-window request is ignored
    ack0 = ack_seen;
    cmd0 = cmd_seen;
    pulse_req(1'b0, 19'h20000, 8'h00, 1);
    repeat (20) @(posedge clk);
    #1;
    check("ignored_ack", 32'(ack_seen - ack0), 32'h0);
    check("ignored_cmd", 32'(cmd_seen - cmd0), 32'h0);

    // Request held high for several cycles yields exactly one access
    r.rdata = 8'h56; r.chk_rdata = 1'b1; r.err = 1'b0; r.chk_addr = 1'b0; r.addr = 22'h11;
    rsp_q.push_back(r);
    ack0 = ack_seen;
    cmd0 = cmd_seen;
    pulse_req(1'b0, 19'h10011, 8'h00, 3);
    repeat (20) @(posedge clk);
    #1;
    check("held_ack_count", 32'(ack_seen - ack0), 32'h1);
    check("held_cmd_count", 32'(cmd_seen - cmd0), 32'h0);

    // Controller never goes busy: timeout 9 cycles after the command pulse
    mem_respond = 1'b0;
    access(1'b0, 19'h10020, 8'h00, 1'b1, 8'hFF, 1'b1, 11, "timeout");
    check("timeout_gap", 32'(last_ack_cyc - last_cmd_cyc), 32'd9);
    mem_respond = 1'b1;
    dout_val    = 16'hA1B2;
    access(1'b0, 19'h10011, 8'h00, 1'b1, 8'hA1, 1'b0, 6, "after_timeout");

    // Reset while waiting for the controller to finish
    ack0 = ack_seen;
    busy_cycles = 6;
    c.we = 1'b0; c.addr = 22'h40; c.din = 16'h0;
    cmd_q.push_back(c);
    pulse_req(1'b0, 19'h10040, 8'h00, 1);
    n = 0;
    while (!mem_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_saw_busy", 32'(mem_busy), 32'h1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check_all_zero("midop_reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_ack", 32'(ack_seen - ack0), 32'h0);
    busy_cycles = 3;
    dout_val    = 16'hC3D4;
    access(1'b0, 19'h10011, 8'h00, 1'b1, 8'hC3, 1'b0, 6, "rst_miss");

    check("cmd_q_drained", 32'(cmd_q.size()), 32'h0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
